// File: rtl/dmac_cfg_mc_if.sv
// Purpose: APB slave bus bundle for the multi-channel DMA configuration block.
// Latency: n/a (signal bundle only).
// Backpressure: none; the slave side ties pready_o high.
// Ports: psel_i/penable_i/paddr_i/pwrite_i/pwdata_i driven by the master;
//        pready_o/prdata_o/pslverr_o driven by the slave.
interface dmac_cfg_mc_if;
    logic        psel_i;
    logic        penable_i;
    logic [11:0] paddr_i;
    logic        pwrite_i;
    logic [31:0] pwdata_i;
    logic        pready_o;
    logic [31:0] prdata_o;
    logic        pslverr_o;

    modport slave (
        input  psel_i, penable_i, paddr_i, pwrite_i, pwdata_i,
        output pready_o, prdata_o, pslverr_o
    );

    modport master (
        output psel_i, penable_i, paddr_i, pwrite_i, pwdata_i,
        input  pready_o, prdata_o, pslverr_o
    );
endinterface

// File: rtl/dmac_cfg_mc.sv
// Purpose: per-channel DMA register bank, start-pulse FSMs and W1C completion irq.
// Latency: zero-wait APB; start_o one cycle after the START write commits.
// Backpressure: none; pready_o is constant 1, illegal accesses answer pslverr_o.
// Ports: clk/rst (sync, active-high); apb (slave modport); src_addr_o/dst_addr_o/
//        byte_len_o flattened per channel; start_o pulses; done_i idle levels; irq_o.
module dmac_cfg_mc #(
    parameter int          CH_CNT  = 4,
    parameter int          LEN_W   = 16,
    parameter logic [31:0] VERSION = 32'h0002_0101
) (
    input  logic                      clk,
    input  logic                      rst,
    dmac_cfg_mc_if.slave              apb,
    output logic [32*CH_CNT-1:0]      src_addr_o,
    output logic [32*CH_CNT-1:0]      dst_addr_o,
    output logic [LEN_W*CH_CNT-1:0]   byte_len_o,
    output logic [CH_CNT-1:0]         start_o,
    input  logic [CH_CNT-1:0]         done_i,
    output logic                      irq_o
);
    localparam int IW = (CH_CNT > 1) ? $clog2(CH_CNT) : 1;

    typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_BUSY} state_t;

    logic [CH_CNT-1:0][31:0]    r_src;
    logic [CH_CNT-1:0][31:0]    r_dst;
    logic [CH_CNT-1:0][LEN_W-1:0] r_len;
    state_t                     r_state     [CH_CNT];
    state_t                     w_state_nxt [CH_CNT];
    logic [CH_CNT-1:0]          r_irq_stat;
    logic [CH_CNT-1:0]          r_irq_en;
    logic                       r_irq;
    logic [31:0]                r_prdata;
    logic                       r_pslverr;

    logic [CH_CNT-1:0]          w_irq_set;
    logic [CH_CNT-1:0]          w_irq_clr;
    logic [CH_CNT-1:0]          w_start_go;
    logic                       w_setup;
    logic                       w_wr_ok;
    logic [9:0]                 w_word;
    logic [6:0]                 w_ch_idx;
    logic [2:0]                 w_reg;
    logic [IW-1:0]              w_sel;
    logic                       w_glb_ok;
    logic                       w_ch_ok;
    logic                       w_err;
    logic [31:0]                w_rdata;
    logic                       w_unused;

    assign w_unused = ^apb.paddr_i[1:0];

    // Setup-phase verdict is held in r_pslverr; the access-phase commit is
    // gated by it so the error reported and the write suppressed always agree.
    assign w_setup = apb.psel_i & ~apb.penable_i;
    assign w_wr_ok = apb.psel_i & apb.penable_i & apb.pwrite_i & ~r_pslverr;

    // Channel window starts at byte 0x100 (word 0x40), 8 words per channel.
    assign w_word   = apb.paddr_i[11:2] - 10'h040;
    assign w_ch_idx = w_word[9:3];
    assign w_reg    = w_word[2:0];
    assign w_sel    = w_ch_idx[IW-1:0];
    assign w_glb_ok = (apb.paddr_i[11:8] == 4'h0) && (apb.paddr_i[7:2] <= 6'd2);
    assign w_ch_ok  = (apb.paddr_i[11:8] != 4'h0) && (w_ch_idx < 7'(CH_CNT))
                      && (w_reg <= 3'd4);

    always_comb begin
        w_rdata = '0;
        w_err   = 1'b0;
        if (w_glb_ok) begin
            case (apb.paddr_i[3:2])
                2'd0:    w_rdata = VERSION;
                2'd1:    w_rdata = 32'(r_irq_stat);
                2'd2:    w_rdata = 32'(r_irq_en);
                default: w_rdata = '0;
            endcase
        end else if (w_ch_ok) begin
            case (w_reg)
                3'd0:    w_rdata = r_src[w_sel];
                3'd1:    w_rdata = r_dst[w_sel];
                3'd2:    w_rdata = 32'(r_len[w_sel]);
                3'd4:    w_rdata = {31'b0, r_state[w_sel] == S_IDLE};
                default: w_rdata = '0;
            endcase
            // Config is frozen while a channel is in flight; zero-length starts are refused.
            if (apb.pwrite_i && (w_reg <= 3'd3) && (r_state[w_sel] != S_IDLE))
                w_err = 1'b1;
            if (apb.pwrite_i && (w_reg == 3'd3) && apb.pwdata_i[0] && (r_len[w_sel] == '0))
                w_err = 1'b1;
        end else begin
            w_err = 1'b1;
        end
    end

    assign w_irq_clr = (w_wr_ok && w_glb_ok && (apb.paddr_i[3:2] == 2'd1))
                       ? apb.pwdata_i[CH_CNT-1:0] : '0;

    always_comb begin
        for (int n = 0; n < CH_CNT; n++) begin
            w_state_nxt[n] = r_state[n];
            w_irq_set[n]   = 1'b0;
            w_start_go[n]  = w_wr_ok && w_ch_ok && (w_reg == 3'd3)
                             && (w_sel == IW'(n)) && apb.pwdata_i[0];
            case (r_state[n])
                S_IDLE:  if (w_start_go[n]) w_state_nxt[n] = S_START;
                S_START: w_state_nxt[n] = S_WAIT;
                // One dead cycle lets the engine drop its stale idle level.
                S_WAIT:  w_state_nxt[n] = S_BUSY;
                S_BUSY:  if (done_i[n]) begin
                             w_state_nxt[n] = S_IDLE;
                             w_irq_set[n]   = 1'b1;
                         end
                default: w_state_nxt[n] = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        for (int n = 0; n < CH_CNT; n++) begin
            if (rst) r_state[n] <= S_IDLE;
            else     r_state[n] <= w_state_nxt[n];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_prdata  <= '0;
            r_pslverr <= 1'b0;
        end else begin
            r_pslverr <= w_setup & w_err;
            if (w_setup & ~apb.pwrite_i) r_prdata <= w_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_src      <= '0;
            r_dst      <= '0;
            r_len      <= '0;
            r_irq_en   <= '0;
            r_irq_stat <= '0;
            r_irq      <= 1'b0;
        end else begin
            if (w_wr_ok && w_glb_ok && (apb.paddr_i[3:2] == 2'd2))
                r_irq_en <= apb.pwdata_i[CH_CNT-1:0];
            // A completion landing on the same edge as its W1C survives.
            r_irq_stat <= (r_irq_stat & ~w_irq_clr) | w_irq_set;
            r_irq      <= |(r_irq_stat & r_irq_en);
            if (w_wr_ok && w_ch_ok) begin
                case (w_reg)
                    3'd0:    r_src[w_sel] <= apb.pwdata_i;
                    3'd1:    r_dst[w_sel] <= apb.pwdata_i;
                    3'd2:    r_len[w_sel] <= apb.pwdata_i[LEN_W-1:0];
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        for (int n = 0; n < CH_CNT; n++) start_o[n] = (r_state[n] == S_START);
    end

    assign src_addr_o    = r_src;
    assign dst_addr_o    = r_dst;
    assign byte_len_o    = r_len;
    assign irq_o         = r_irq;
    assign apb.pready_o  = 1'b1;
    assign apb.prdata_o  = r_prdata;
    assign apb.pslverr_o = r_pslverr;
endmodule
